// File: rtl/param_ram_ctrl.sv
// Simple-dual-port RAM with registered read, selectable read-during-write
// behaviour and a clear engine that sweeps every word to INIT_VAL.
module param_ram_ctrl #(
    parameter int                DATA_W    = 3,
    parameter int                ADDR_W    = 5,
    parameter int                READ_MODE = 0,
    parameter logic [DATA_W-1:0] INIT_VAL  = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              clear,
    output logic              busy
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] sweep_addr_reg;
    logic [DATA_W-1:0] rd_data_reg;
    logic              rd_valid_reg;
    logic              busy_reg;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              fwd_hit;

    // The sweep owns the write port while clearing; holding reset keeps the array untouched.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        if (state_reg == ST_CLEAR) begin
            mem_we    = reset_n;
            mem_waddr = sweep_addr_reg;
            mem_wdata = INIT_VAL;
        end else begin
            mem_we    = wr_en;
        end
    end

    generate
        if (READ_MODE == 1) begin : g_new_data
            assign fwd_hit = wr_en && (wr_addr == rd_addr);
        end else begin : g_old_data
            assign fwd_hit = 1'b0;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_CLEAR;
            sweep_addr_reg <= '0;
            busy_reg       <= 1'b1;
            rd_data_reg    <= '0;
            rd_valid_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_CLEAR: begin
                    rd_valid_reg   <= 1'b0;
                    sweep_addr_reg <= sweep_addr_reg + ADDR_W'(1);
                    if (sweep_addr_reg == ADDR_W'(DEPTH - 1)) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    rd_valid_reg <= rd_en;
                    if (rd_en) begin
                        rd_data_reg <= fwd_hit ? wr_data : mem[rd_addr];
                    end
                    if (clear) begin
                        state_reg      <= ST_CLEAR;
                        sweep_addr_reg <= '0;
                        busy_reg       <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_CLEAR;
                end
            endcase
        end
    end

    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_param_ram_ctrl.sv
// Randomised bench for param_ram_ctrl: both read-during-write modes checked
// against an array-level model, plus a small-geometry instance with INIT_VAL.
module tb_param_ram_ctrl;
    localparam int DW    = 3;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset_n;
    logic          wr_en, rd_en, clear;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data0, rd_data1;
    logic          rd_valid0, rd_valid1, busy0, busy1;

    logic          s_wr_en, s_rd_en, s_clear;
    logic [1:0]    s_wr_addr, s_rd_addr;
    logic [2:0]    s_wr_data, s_rd_data;
    logic          s_rd_valid, s_busy;

    param_ram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .READ_MODE(0), .INIT_VAL(3'b000)) u_dut_old (
        .clock(clock), .reset_n(reset_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0),
        .clear(clear), .busy(busy0)
    );

    param_ram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .READ_MODE(1), .INIT_VAL(3'b000)) u_dut_new (
        .clock(clock), .reset_n(reset_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1),
        .clear(clear), .busy(busy1)
    );

    param_ram_ctrl #(.DATA_W(3), .ADDR_W(2), .READ_MODE(0), .INIT_VAL(3'b101)) u_dut_small (
        .clock(clock), .reset_n(reset_n),
        .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
        .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .rd_valid(s_rd_valid),
        .clear(s_clear), .busy(s_busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: word array plus remaining sweep cycles.
    logic [DW-1:0] m_mem [DEPTH];
    int            m_left;
    logic [DW-1:0] m_rd_old, m_rd_new;
    logic          m_valid;
    int            s_busy_cycles = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_fill();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    endtask

    task automatic model_reset();
        m_left   = DEPTH;
        m_rd_old = '0;
        m_rd_new = '0;
        m_valid  = 1'b0;
        model_fill();
    endtask

    task automatic tick();
        if (s_busy) s_busy_cycles++;
        @(posedge clock);
        if (reset_n) begin
            if (m_left > 0) begin
                m_left--;
                m_valid = 1'b0;
            end else begin
                if (rd_en) begin
                    m_rd_old = m_mem[rd_addr];
                    m_rd_new = (wr_en && wr_addr == rd_addr) ? wr_data : m_mem[rd_addr];
                    m_valid  = 1'b1;
                end else begin
                    m_valid  = 1'b0;
                end
                if (wr_en) m_mem[wr_addr] = wr_data;
                if (clear) begin
                    m_left = DEPTH;
                    model_fill();
                end
            end
        end
        #1;
        $display("t=%0t wr=%b a=%0d d=%0d rd=%b a=%0d clr=%b | busy=%b v=%b rd_old=%0d rd_new=%0d",
                 $time, wr_en, wr_addr, wr_data, rd_en, rd_addr, clear,
                 busy0, rd_valid0, rd_data0, rd_data1);
        check("busy_old", 32'(busy0), 32'(m_left > 0));
        check("busy_new", 32'(busy1), 32'(m_left > 0));
        check("valid_old", 32'(rd_valid0), 32'(m_valid));
        check("valid_new", 32'(rd_valid1), 32'(m_valid));
        check("rd_old", 32'(rd_data0), 32'(m_rd_old));
        check("rd_new", 32'(rd_data1), 32'(m_rd_new));
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
    endtask

    task automatic do_write(input int a, input int d);
        idle_inputs();
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = DW'(d);
        tick();
    endtask

    task automatic do_read(input int a);
        idle_inputs();
        rd_en = 1'b1; rd_addr = AW'(a);
        tick();
    endtask

    task automatic count_busy(input string tag, input bit random_ports);
        int cnt;
        cnt = 0;
        while (busy0 && cnt < 100) begin
            idle_inputs();
            if (random_ports) begin
                wr_en   = 1'($urandom);
                rd_en   = 1'($urandom);
                clear   = 1'($urandom);
                wr_addr = AW'($urandom);
                rd_addr = AW'($urandom);
                wr_data = DW'($urandom);
            end
            tick();
            cnt++;
        end
        check(tag, 32'(cnt), 32'(DEPTH));
    endtask

    initial begin
        idle_inputs();
        s_wr_en = 1'b0; s_rd_en = 1'b0; s_clear = 1'b0;
        s_wr_addr = '0; s_rd_addr = '0; s_wr_data = '0;
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check("reset_busy", 32'(busy0), 32'd1);
        check("reset_valid", 32'(rd_valid0), 32'd0);
        check("reset_rd", 32'(rd_data0), 32'd0);
        check("reset_small_busy", 32'(s_busy), 32'd1);
        #2 reset_n = 1'b1;

        // Power-up sweep, then reads of cleared words.
        count_busy("sweep_len_reset", 1'b0);
        check("small_sweep_len", 32'(s_busy_cycles), 32'd4);
        foreach (m_mem[i]) ;
        do_read(0);  check("t1_rd0", 32'(rd_data0), 32'd0);  check("t1_v0", 32'(rd_valid0), 32'd1);
        do_read(17); check("t1_rd17", 32'(rd_data0), 32'd0);
        do_read(31); check("t1_rd31", 32'(rd_data0), 32'd0);
        idle_inputs(); tick(); check("t1_pulse", 32'(rd_valid0), 32'd0);

        // Small geometry: every word reads back INIT_VAL.
        for (int i = 0; i < 4; i++) begin
            s_rd_en = 1'b1; s_rd_addr = 2'(i);
            tick();
            check("small_rd", 32'(s_rd_data), 32'd5);
            check("small_valid", 32'(s_rd_valid), 32'd1);
        end
        s_rd_en = 1'b0;
        tick();
        check("small_pulse", 32'(s_rd_valid), 32'd0);

        // Directed writes then back-to-back reads.
        do_write(0, 7); do_write(5, 2); do_write(10, 1); do_write(15, 6); do_write(20, 5);
        do_read(5);  check("t2_rd5", 32'(rd_data0), 32'd2);
        do_read(15); check("t2_rd15", 32'(rd_data0), 32'd6);
        do_read(20); check("t2_rd20", 32'(rd_data0), 32'd5); check("t2_v", 32'(rd_valid0), 32'd1);

        // Read-during-write on the same address.
        do_write(9, 4);
        idle_inputs();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 3'd3; rd_en = 1'b1; rd_addr = 5'd9;
        tick();
        check("t3_old", 32'(rd_data0), 32'd4);
        check("t3_new", 32'(rd_data1), 32'd3);
        do_read(9);
        check("t3_after_old", 32'(rd_data0), 32'd3);
        check("t3_after_new", 32'(rd_data1), 32'd3);

        // Clear with a same-edge write; ports are ignored during the sweep.
        idle_inputs();
        clear = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 3'd7;
        tick();
        check("t4_busy", 32'(busy0), 32'd1);
        count_busy("sweep_len_clear", 1'b1);
        do_read(3); check("t4_rd3", 32'(rd_data0), 32'd0);

        // Reset mid-sweep restarts a full sweep.
        do_write(1, 6);
        do_read(1); check("t5_pre", 32'(rd_data0), 32'd6);
        idle_inputs(); clear = 1'b1; tick();
        idle_inputs();
        repeat (12) tick();
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        check("t5_busy", 32'(busy0), 32'd1);
        check("t5_rd", 32'(rd_data0), 32'd0);
        check("t5_valid", 32'(rd_valid0), 32'd0);
        repeat (2) @(posedge clock);
        #3 reset_n = 1'b1;
        count_busy("sweep_len_rerun", 1'b0);

        // Random traffic with frequent address collisions.
        for (int n = 0; n < 700; n++) begin
            idle_inputs();
            wr_en   = 1'($urandom);
            rd_en   = 1'($urandom);
            clear   = ($urandom_range(0, 99) == 0);
            wr_addr = AW'($urandom);
            rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom);
            wr_data = DW'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
